// File: rtl/rom_burst_reader.sv
// Burst reader for a 64x8 registered-output ROM. It issues sequential reads
// into a 2-entry FIFO and streams the words out under ready/valid flow control.
module rom_burst_reader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] base_addr,
    input  logic [5:0] len,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] rom_addr_q, rom_addr_d;
    logic [6:0] remaining_q, remaining_d;
    logic       inflight_q, inflight_d;
    logic [1:0] fifo_count_q, fifo_count_d;
    logic [7:0] entry0_q, entry0_d;
    logic [7:0] entry1_q, entry1_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       busy_q, busy_d;

    logic       pop_s;
    logic       push_s;
    logic       issue_s;
    logic       done_s;
    logic [2:0] occ_s;

    // Next-state logic for the FSM, read issue and the FIFO.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        remaining_d  = remaining_q;
        fifo_count_d = fifo_count_q;
        entry0_d     = entry0_q;
        entry1_d     = entry1_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;

        pop_s   = (fifo_count_q != 2'd0) && out_ready;
        push_s  = inflight_q;
        // Occupancy after this cycle's pop; pop implies count>0 so no underflow.
        occ_s   = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s = (state_q == RUN) && (remaining_q != 7'd0) && (occ_s < 3'd2);
        done_s  = (state_q == DRAIN) && pop_s && (fifo_count_q == 2'd1) && !inflight_q;
        inflight_d = issue_s;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    rom_addr_d  = base_addr;
                    remaining_d = (len == 6'd0) ? 7'd64 : {1'b0, len};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    rom_addr_d  = rom_addr_q + 6'd1;
                    remaining_d = remaining_q - 7'd1;
                    if (remaining_q == 7'd1) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push_s) begin
            if (wr_ptr_q) begin
                entry1_d = rom_data;
            end else begin
                entry0_d = rom_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + 2'd1;
            2'b01:   fifo_count_d = fifo_count_q - 2'd1;
            default: fifo_count_d = fifo_count_q;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rom_addr_q   <= 6'd0;
            remaining_q  <= 7'd0;
            inflight_q   <= 1'b0;
            fifo_count_q <= 2'd0;
            entry0_q     <= 8'd0;
            entry1_q     <= 8'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            remaining_q  <= remaining_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            entry0_q     <= entry0_d;
            entry1_q     <= entry1_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            busy_q       <= busy_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign out_data  = rd_ptr_q ? entry1_q : entry0_q;
    assign out_valid = (fifo_count_q != 2'd0);
    assign busy      = busy_q;
    // done must coincide with the final transfer, so it follows out_ready.
    assign done      = done_s;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench for rom_burst_reader with a registered ROM model (rom[i]=i).
module tb_rom_burst_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] base_addr;
    logic [5:0] len;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    rom_burst_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ROM model: registered read, contents equal to the address.
    always @(posedge clk) rom_data <= {2'b00, rom_addr};

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   xfers = 0;
    int   cyc   = 0;
    int   rdy_mode = 0;
    logic prev_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_ready();
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        cyc++;
    endtask

    task automatic push_burst(input logic [5:0] b, input logic [5:0] l);
        int   n;
        exp_t e;
        n = (l == 6'd0) ? 64 : int'(l);
        for (int i = 0; i < n; i++) begin
            e.data = {2'b00, 6'(int'(b) + i)};
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    // Called just after a rising edge; leaves start low one cycle later.
    task automatic start_burst(input logic [5:0] b, input logic [5:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        push_burst(b, l);
        drive_ready();
        @(posedge clk); #1;
        start = 1'b0;
        drive_ready();
    endtask

    // Returns at the start of the cycle after done.
    task automatic wait_done();
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
            drive_ready();
            n++;
        end
        check_eq("burst_done_seen", 32'(seen), 32'd1);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks done/busy/occupancy.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            check_eq("occupancy_le2", 32'(dut.fifo_count_q) + 32'(dut.inflight_q), 32'(dut.fifo_count_q) + 32'(dut.inflight_q) > 32'd2 ? 32'd2 : 32'(dut.fifo_count_q) + 32'(dut.inflight_q));
            if (out_valid && out_ready) begin
                check_eq("word_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("out_data", 32'(out_data), 32'(e.data));
                    check_eq("done_on_last", 32'(done), 32'(e.last));
                end
                xfers++;
            end else begin
                check_eq("done_no_xfer", 32'(done), 32'd0);
            end
            if (prev_done) check_eq("busy_after_done", 32'(busy), 32'd0);
            prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = 6'd0;
        len       = 6'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // base 32, len 4, ready held high: cycle-exact latency table.
        rdy_mode  = 0;
        out_ready = 1'b1;
        start     = 1'b1;
        base_addr = 6'd32;
        len       = 6'd4;
        push_burst(6'd32, 6'd4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("lat_valid_k%0d", k), 32'(out_valid), 32'((k >= 3) && (k <= 6)));
            check_eq($sformatf("lat_busy_k%0d", k), 32'(busy), 32'((k >= 1) && (k <= 6)));
            check_eq($sformatf("lat_done_k%0d", k), 32'(done), 32'(k == 6));
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_eq("t1_sb_drained", 32'(sb.size()), 32'd0);

        // Address wrap, then back-to-back full 64-word burst started right after done.
        start_burst(6'd62, 6'd4);
        wait_done();
        start_burst(6'd0, 6'd0);
        wait_done();

        // Ready pattern 1,0,0 repeating.
        rdy_mode = 1;
        cyc      = 0;
        start_burst(6'd10, 6'd8);
        wait_done();

        // Random ready with wrap.
        rdy_mode = 2;
        start_burst(6'd50, 6'd20);
        wait_done();

        // Start while busy is ignored.
        rdy_mode = 0;
        start_burst(6'd20, 6'd3);
        start     = 1'b1;
        base_addr = 6'd40;
        len       = 6'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        #1;

        // Reset after the third transfer of a len=8 burst.
        x0 = xfers;
        start_burst(6'd0, 6'd8);
        for (int n = 0; n < 100 && (xfers - x0) < 3; n++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        check_eq("abort_three_xfers", 32'(xfers - x0), 32'd3);
        reset     = 1'b1;
        out_ready = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        x0 = xfers;
        start_burst(6'd5, 6'd2);
        wait_done();
        repeat (6) @(posedge clk);
        #1;
        check_eq("post_abort_words", 32'(xfers - x0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
